// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and constants for the traffic light controller.
// State enum, per-approach lamp codes, default timing, lamp decode helper.
// Build option: TLC_EMERG_PREEMPT_EN adds the ST_EMG_GREEN state.
package tlc_pkg;

   localparam int TLC_NUM_DIR  = 4;
   localparam int TLC_CNT_W    = 8;
   localparam int TLC_GREEN_T  = 7;
   localparam int TLC_YELLOW_T = 2;
   localparam int TLC_ALLRED_T = 1;
   localparam int TLC_BLINK_T  = 4;

   // {red,yellow,green}
   localparam logic [2:0] LT_RED    = 3'b100;
   localparam logic [2:0] LT_YELLOW = 3'b010;
   localparam logic [2:0] LT_GREEN  = 3'b001;
   localparam logic [2:0] LT_OFF    = 3'b000;

   typedef enum logic [2:0] {
      ST_ALLRED    = 3'd0,
      ST_GREEN     = 3'd1,
      ST_YELLOW    = 3'd2,
      ST_FLASH     = 3'd3
`ifdef TLC_EMERG_PREEMPT_EN
      ,
      ST_EMG_GREEN = 3'd4
`endif
   } tlc_state_e;

   // Lamp for one approach; own = approach holds the phase.
   function automatic logic [2:0] tlc_lamp(
      tlc_state_e st,
      logic       own,
      logic       blink
   );
      logic [2:0] l;
      l = LT_RED;
      unique case (1'b1)
         (st == ST_FLASH):     l = blink ? LT_OFF : LT_YELLOW;
         (st == ST_YELLOW):    l = own ? LT_YELLOW : LT_RED;
         (st == ST_GREEN):     l = own ? LT_GREEN : LT_RED;
`ifdef TLC_EMERG_PREEMPT_EN
         (st == ST_EMG_GREEN): l = own ? LT_GREEN : LT_RED;
`endif
         default:              l = LT_RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: loadable down-counter, expire while count is zero.
// Ports: clk, rst_n (async low), load, load_val[CNT_W], expire.
module tlc_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/traffic_light_controller_param.sv
// traffic_light_controller_param: N-approach rotating signal controller
// with flashing-yellow override and optional emergency preemption.
// Ports: clk, rst_n (async low), flash, emg_req, emg_dir -> emg_ack,
//        light[3*NUM_DIR] ({r,y,g} per approach), cur_dir.
// Build option: define TLC_EMERG_PREEMPT_EN to enable preemption;
// otherwise emg_req/emg_dir are ignored and emg_ack is 0.
module traffic_light_controller_param
   import tlc_pkg::*;
#(
   parameter int  NUM_DIR  = TLC_NUM_DIR,
   parameter int  CNT_W    = TLC_CNT_W,
   parameter int  GREEN_T  = TLC_GREEN_T,
   parameter int  YELLOW_T = TLC_YELLOW_T,
   parameter int  ALLRED_T = TLC_ALLRED_T,
   parameter int  BLINK_T  = TLC_BLINK_T,
   localparam int DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flash,
   input  logic                 emg_req,
   input  logic [DW-1:0]        emg_dir,
   output logic                 emg_ack,
   output logic [3*NUM_DIR-1:0] light,
   output logic [DW-1:0]        cur_dir
);

   localparam logic [DW-1:0]    LAST   = DW'(NUM_DIR - 1);
   localparam logic [CNT_W-1:0] AR_LEN = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] GR_LEN = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YE_LEN = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] BK_LEN = CNT_W'(BLINK_T - 1);
   // First ALLRED after reset already spent one clock with count 0.
   localparam logic [CNT_W-1:0] AR_PRE =
      CNT_W'((ALLRED_T > 1) ? ALLRED_T - 2 : 0);

   tlc_state_e       state;
   tlc_state_e       nxt_state;
   logic [DW-1:0]    nxt_dir;
   logic [DW-1:0]    dir_inc;
   logic [DW-1:0]    tgt;
   logic [DW-1:0]    nxt_tgt;
   logic             pend;
   logic             nxt_pend;
   logic             primed;
   logic             prime_ld;
   logic             blink;
   logic             ph_load;
   logic             ph_exp;
   logic [CNT_W-1:0] ph_val;
   logic             bk_load;
   logic             bk_exp;

   assign dir_inc = (cur_dir == LAST) ? '0 : cur_dir + 1'b1;

   always_comb begin
      nxt_state = state;
      nxt_dir   = cur_dir;
      nxt_pend  = pend;
      nxt_tgt   = tgt;
      prime_ld  = 1'b0;
`ifdef TLC_EMERG_PREEMPT_EN
      // A request seen in YELLOW/ALLRED waits for the phase to finish.
      if (emg_req && !pend &&
          (state == ST_YELLOW || state == ST_ALLRED)) begin
         nxt_pend = 1'b1;
         nxt_tgt  = emg_dir;
      end
`endif
      if (flash) begin
         nxt_state = ST_FLASH;
         nxt_pend  = 1'b0;
      end else begin
         unique case (1'b1)
            (state == ST_ALLRED): begin
               if (!primed && ALLRED_T > 1) begin
                  prime_ld = 1'b1;
               end else if (ph_exp) begin
                  nxt_state = ST_GREEN;
                  nxt_dir   = dir_inc;
`ifdef TLC_EMERG_PREEMPT_EN
                  if (nxt_pend) begin
                     nxt_state = ST_EMG_GREEN;
                     nxt_dir   = nxt_tgt;
                     nxt_pend  = 1'b0;
                  end
`endif
               end
            end
            (state == ST_GREEN): begin
               if (ph_exp) begin
                  nxt_state = ST_YELLOW;
               end
`ifdef TLC_EMERG_PREEMPT_EN
               if (emg_req) begin
                  if (emg_dir == cur_dir) begin
                     nxt_state = ST_EMG_GREEN;
                  end else begin
                     nxt_state = ST_YELLOW;
                     nxt_pend  = 1'b1;
                     nxt_tgt   = emg_dir;
                  end
               end
`endif
            end
            (state == ST_YELLOW): begin
               if (ph_exp) begin
                  nxt_state = ST_ALLRED;
               end
            end
`ifdef TLC_EMERG_PREEMPT_EN
            (state == ST_EMG_GREEN): begin
               if (!emg_req) begin
                  nxt_state = ST_YELLOW;
               end
            end
`endif
            (state == ST_FLASH): begin
               nxt_state = ST_ALLRED;
               nxt_dir   = LAST;
               nxt_pend  = 1'b0;
            end
            default: begin
               nxt_state = ST_ALLRED;
            end
         endcase
      end
   end

   // Phase timer reloads on every state change with the new length.
   assign ph_load = prime_ld || (nxt_state != state);

   always_comb begin
      ph_val = '0;
      if (prime_ld) begin
         ph_val = AR_PRE;
      end else begin
         unique case (1'b1)
            (nxt_state == ST_ALLRED): ph_val = AR_LEN;
            (nxt_state == ST_GREEN):  ph_val = GR_LEN;
            (nxt_state == ST_YELLOW): ph_val = YE_LEN;
            default:                  ph_val = '0;
         endcase
      end
   end

   // Blink timer sits preloaded outside FLASH.
   assign bk_load = (state != ST_FLASH) || bk_exp;

   tlc_phase_timer #(
      .CNT_W(CNT_W)
   ) u_phase (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ph_load),
      .load_val(ph_val),
      .expire  (ph_exp)
   );

   tlc_phase_timer #(
      .CNT_W(CNT_W)
   ) u_blink (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (bk_load),
      .load_val(BK_LEN),
      .expire  (bk_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_ALLRED;
         cur_dir <= LAST;
         pend    <= 1'b0;
         tgt     <= '0;
         primed  <= 1'b0;
         blink   <= 1'b0;
      end else begin
         state   <= nxt_state;
         cur_dir <= nxt_dir;
         pend    <= nxt_pend;
         tgt     <= nxt_tgt;
         primed  <= 1'b1;
         if (state != ST_FLASH) begin
            blink <= 1'b0;
         end else if (bk_exp) begin
            blink <= ~blink;
         end
      end
   end

   always_comb begin
      light = '0;
      for (int k = 0; k < NUM_DIR; k++) begin
         light[3*k +: 3] = tlc_lamp(state, cur_dir == DW'(k), blink);
      end
   end

`ifdef TLC_EMERG_PREEMPT_EN
   assign emg_ack = (state == ST_EMG_GREEN);
`else
   assign emg_ack = 1'b0;
   logic unused_emg;
   assign unused_emg = ^{emg_req, emg_dir};
`endif

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Bench for traffic_light_controller_param: directed scenarios then
// random flash/emergency/reset traffic against a phase-level model.
module tb_traffic_light_controller_param;

   localparam int N   = 4;
   localparam int DW  = 2;
   localparam int GT  = 7;
   localparam int YT  = 2;
   localparam int AT  = 1;
   localparam int BT  = 4;
`ifdef TLC_EMERG_PREEMPT_EN
   localparam bit EMG = 1'b1;
`else
   localparam bit EMG = 1'b0;
`endif

   localparam int P_AR = 0;
   localparam int P_GR = 1;
   localparam int P_YE = 2;
   localparam int P_EG = 3;
   localparam int P_FL = 4;

   logic            clk;
   logic            rst_n;
   logic            flash;
   logic            emg_req;
   logic [DW-1:0]   emg_dir;
   logic            emg_ack;
   logic [3*N-1:0]  light;
   logic [DW-1:0]   cur_dir;

   int vectors;
   int miscompares;
   int m_ph;
   int m_dir;
   int m_age;
   int m_pend;
   int m_tgt;
   int emg_left;
   int fl_left;

   traffic_light_controller_param #(
      .NUM_DIR (N),
      .CNT_W   (8),
      .GREEN_T (GT),
      .YELLOW_T(YT),
      .ALLRED_T(AT),
      .BLINK_T (BT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .flash  (flash),
      .emg_req(emg_req),
      .emg_dir(emg_dir),
      .emg_ack(emg_ack),
      .light  (light),
      .cur_dir(cur_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_ph   = P_AR;
      m_age  = 0;
      m_dir  = N - 1;
      m_pend = 0;
      m_tgt  = 0;
   endtask

   // One rising edge of the phase model, using the inputs now applied.
   task automatic model_step();
      int ed;
      ed = int'(emg_dir);
      if (flash) begin
         if (m_ph == P_FL) m_age++;
         else begin
            m_ph  = P_FL;
            m_age = 0;
         end
         m_pend = 0;
         return;
      end
      if (EMG && emg_req && m_pend == 0 &&
          (m_ph == P_YE || m_ph == P_AR)) begin
         m_pend = 1;
         m_tgt  = ed;
      end
      case (m_ph)
         P_FL: begin
            m_ph   = P_AR;
            m_age  = 0;
            m_dir  = N - 1;
            m_pend = 0;
         end
         P_AR: begin
            if (m_age >= AT - 1) begin
               m_age = 0;
               if (m_pend != 0) begin
                  m_ph   = P_EG;
                  m_dir  = m_tgt;
                  m_pend = 0;
               end else begin
                  m_ph  = P_GR;
                  m_dir = (m_dir + 1) % N;
               end
            end else m_age++;
         end
         P_GR: begin
            if (EMG && emg_req) begin
               m_age = 0;
               if (ed == m_dir) m_ph = P_EG;
               else begin
                  m_ph   = P_YE;
                  m_pend = 1;
                  m_tgt  = ed;
               end
            end else if (m_age >= GT - 1) begin
               m_ph  = P_YE;
               m_age = 0;
            end else m_age++;
         end
         P_YE: begin
            if (m_age >= YT - 1) begin
               m_ph  = P_AR;
               m_age = 0;
            end else m_age++;
         end
         default: begin
            if (!emg_req) begin
               m_ph  = P_YE;
               m_age = 0;
            end
         end
      endcase
   endtask

   function automatic logic [3*N-1:0] exp_light();
      logic [3*N-1:0] v;
      logic [2:0]     l;
      v = '0;
      for (int k = 0; k < N; k++) begin
         if (m_ph == P_FL)
            l = (((m_age / BT) % 2) == 0) ? 3'b010 : 3'b000;
         else if (m_ph == P_AR || k != m_dir) l = 3'b100;
         else if (m_ph == P_YE) l = 3'b010;
         else l = 3'b001;
         v[3*k +: 3] = l;
      end
      return v;
   endfunction

   task automatic check(string tag);
      logic [3*N-1:0] el;
      logic           ea;
      logic [DW-1:0]  ed;
      el = exp_light();
      ea = (m_ph == P_EG);
      ed = DW'(m_dir);
      vectors++;
      assert (light === el) else begin
         miscompares++;
         $error("FAIL %s light got %h want %h", tag, light, el);
      end
      vectors++;
      assert (emg_ack === ea) else begin
         miscompares++;
         $error("FAIL %s emg_ack got %b want %b", tag, emg_ack, ea);
      end
      vectors++;
      assert (cur_dir === ed) else begin
         miscompares++;
         $error("FAIL %s cur_dir got %0d want %0d", tag, cur_dir, ed);
      end
   endtask

   task automatic expect_lit(string tag, logic [3*N-1:0] wl,
                             logic wa);
      vectors++;
      assert (light === wl) else begin
         miscompares++;
         $error("FAIL %s light got %h want %h", tag, light, wl);
      end
      vectors++;
      assert (emg_ack === wa) else begin
         miscompares++;
         $error("FAIL %s emg_ack got %b want %b", tag, emg_ack, wa);
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_step();
      #1;
      check(tag);
   endtask

   task automatic wait_phase(string tag, int ph, int d, int limit);
      int n;
      n = 0;
      while (!(m_ph == ph && (d < 0 || m_dir == d)) && n < limit) begin
         step(tag);
         n++;
      end
      vectors++;
      assert (n < limit) else begin
         miscompares++;
         $error("FAIL %s timeout got %0d steps want < %0d", tag, n, limit);
      end
   endtask

   task automatic reset_pulse(string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check(tag);
      expect_lit(tag, 12'h924, 1'b0);
      @(posedge clk);
      #1;
      check(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      emg_left    = 0;
      fl_left     = 0;
      rst_n       = 1'b0;
      flash       = 1'b0;
      emg_req     = 1'b0;
      emg_dir     = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset");
      expect_lit("reset_red", 12'h924, 1'b0);
      rst_n = 1'b1;
      check("release");

      // rotation: green0, green1 ten clocks later, green0 after 40
      step("rot");
      expect_lit("green0", 12'h921, 1'b0);
      repeat (10) step("rot");
      expect_lit("green1", 12'h90C, 1'b0);
      repeat (30) step("rot");
      expect_lit("period40", 12'h921, 1'b0);

      // preempt to approach 2 from green0 clock 3
      repeat (2) step("g0");
      emg_req = 1'b1;
      emg_dir = 2'd2;
      repeat (4) step("emg2");
      if (EMG) expect_lit("emg2_green", 12'h864, 1'b1);
      repeat (5) step("emg2_hold");
      emg_req = 1'b0;
      repeat (4) step("emg2_exit");
      if (EMG) expect_lit("after_emg_g3", 12'h324, 1'b0);

      // same-approach preemption: no yellow
      wait_phase("to_g1", P_GR, 1, 60);
      emg_req = 1'b1;
      emg_dir = 2'd1;
      step("emg1");
      if (EMG) expect_lit("emg1_direct", 12'h90C, 1'b1);
      repeat (3) step("emg1_hold");
      emg_req = 1'b0;
      repeat (3) step("emg1_exit");

      // flash from yellow
      wait_phase("to_yel", P_YE, -1, 60);
      flash = 1'b1;
      step("fl");
      expect_lit("flash_on", 12'h492, 1'b0);
      repeat (3) step("fl");
      step("fl");
      expect_lit("flash_off", 12'h000, 1'b0);
      repeat (3) step("fl");
      step("fl");
      expect_lit("flash_on2", 12'h492, 1'b0);
      flash = 1'b0;
      step("fl_exit");
      expect_lit("fl_allred", 12'h924, 1'b0);
      step("fl_exit");
      expect_lit("fl_green0", 12'h921, 1'b0);

      // reset in the middle of emergency green
      emg_req = 1'b1;
      emg_dir = 2'd3;
      if (EMG) wait_phase("to_emg", P_EG, -1, 60);
      else repeat (5) step("noemg");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_async");
      expect_lit("rst_async_red", 12'h924, 1'b0);
      emg_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold");
      rst_n = 1'b1;
      step("rst_rel");
      expect_lit("rst_green0", 12'h921, 1'b0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if (emg_left == 0) begin
            emg_req  = ($urandom_range(0, 2) == 0);
            emg_dir  = DW'($urandom_range(0, N - 1));
            emg_left = $urandom_range(1, 25);
         end else emg_left--;
         if ($urandom_range(0, 7) == 0)
            emg_dir = DW'($urandom_range(0, N - 1));
         if (fl_left == 0) begin
            flash   = ($urandom_range(0, 59) == 0);
            fl_left = flash ? $urandom_range(3, 20) : 0;
         end else fl_left--;
         if ($urandom_range(0, 199) == 0) reset_pulse("rnd_rst");
         else step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/traffic_light_controller_param.md
TRAFFIC_LIGHT_CONTROLLER_PARAM -- requirements
Module: traffic_light_controller_param

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, meaning number of approaches (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning phase counter width.
REQ-003 SHALL have parameters GREEN_T, YELLOW_T and ALLRED_T, defaults 7, 2 and 1, meaning phase lengths in clocks, each 1..2^CNT_W-1.
REQ-004 SHALL have parameter BLINK_T, default 4, meaning clocks per half-period of the flash blink.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port flash, input, 1 bit: fault/maintenance request for flashing yellow.
REQ-008 SHALL have port emg_req, input, 1 bit: emergency preemption request, level-held.
REQ-009 SHALL have port emg_dir, input, clog2(NUM_DIR) bits: approach to preempt to, sampled while emg_req is high.
REQ-010 SHALL have port emg_ack, output, 1 bit: high while the preempted approach holds emergency green.
REQ-011 SHALL have port light, output, 3*NUM_DIR bits: per approach {red,yellow,green}; approach k occupies bits 3k+2..3k; red=100, yellow=010, green=001.
REQ-012 SHALL have port cur_dir, output, clog2(NUM_DIR) bits: approach currently owning the phase.

Function
REQ-013 SHALL implement states ALLRED, GREEN, YELLOW, EMG_GREEN and FLASH.
REQ-014 SHALL hold each timed state (ALLRED, GREEN, YELLOW) for exactly its *_T clocks, then advance on the next edge.
REQ-015 SHALL sequence normal operation as ALLRED -> GREEN(cur_dir) -> YELLOW(cur_dir) -> ALLRED; cur_dir SHALL increment on ALLRED exit and wrap from NUM_DIR-1 to 0.
REQ-016 SHALL drive green (GREEN, EMG_GREEN) or yellow (YELLOW) only on approach cur_dir, and red on all others; ALLRED SHALL drive red on every approach.
REQ-017 SHALL, when emg_req is high in GREEN with cur_dir != emg_dir, abort green immediately and enter YELLOW for the full YELLOW_T, then ALLRED, then EMG_GREEN with cur_dir = emg_dir.
REQ-018 SHALL, when emg_req is high in GREEN with cur_dir == emg_dir, enter EMG_GREEN on the next edge with no yellow.
REQ-019 SHALL, when emg_req arrives during YELLOW or ALLRED, finish that phase and then go to ALLRED->EMG_GREEN (or directly EMG_GREEN at ALLRED exit), loading cur_dir = emg_dir.
REQ-020 SHALL hold EMG_GREEN while emg_req is high, ignoring emg_dir changes; emg_ack SHALL be high only in EMG_GREEN.
REQ-021 SHALL, on emg_req low in EMG_GREEN, go to YELLOW then ALLRED, resuming normal rotation at cur_dir+1 (wrapped).
REQ-022 SHALL enter FLASH on the edge after flash goes high, from any state; flash SHALL have priority over emg_req.
REQ-023 SHALL, in FLASH, drive all approaches 010 for BLINK_T clocks and then 000 for BLINK_T clocks, repeating, starting with 010.
REQ-024 SHALL, on flash low, leave FLASH to ALLRED with cur_dir = NUM_DIR-1, so the next green is approach 0.
REQ-025 SHALL decode light, emg_ack and cur_dir combinationally from registered state only, with no input-to-output paths.

Reset
REQ-026 SHALL, while rst_n is low, force state ALLRED, phase counter 0, cur_dir = NUM_DIR-1 and blink phase 0.
REQ-027 SHALL, during reset, hold light at all 100, emg_ack at 0 and cur_dir at NUM_DIR-1.
REQ-028 SHALL, on rst_n release, complete ALLRED_T clocks and then green approach 0.
REQ-029 SHALL, on reset asserted mid-phase or mid-preemption, discard the phase and any pending emergency request.

Configuration
REQ-030 SHALL compile in emergency preemption (REQ-017..021) when macro TLC_EMERG_PREEMPT_EN is defined.
REQ-031 SHALL, when TLC_EMERG_PREEMPT_EN is undefined, keep emg_req and emg_dir ports but ignore them, tie emg_ack to 0, and omit EMG_GREEN.

Structure
REQ-032 SHALL place the state enum, the light encodings (RED/YELLOW/GREEN/OFF) and the default timing constants in a shared package, tlc_pkg.
REQ-033 SHALL use one sub-module, tlc_phase_timer: a CNT_W loadable down-counter with a load input and an expire output, reused for the phase timer and the blink timer.

Verification
REQ-034 SHALL verify, with defaults, release of rst_n: 1 clock all-red, approach 0 green for 7 clocks, yellow for 2, all-red for 1, then approach 1 green; the rotation SHALL repeat every 40 clocks.
REQ-035 SHALL verify emg_req=1 with emg_dir=2 at clock 3 of approach 0 green: yellow for 2, all-red for 1, then approach 2 green with emg_ack=1 until emg_req drops, then yellow 2, all-red 1, and approach 3 green.
REQ-036 SHALL verify emg_req with emg_dir=1 during approach 1 green: EMG_GREEN next edge, no yellow, emg_ack=1.
REQ-037 SHALL verify flash=1 during YELLOW: all approaches 010 for 4 clocks, 000 for 4 clocks, repeating; after flash=0, all-red for 1 then approach 0 green.
REQ-038 SHALL verify rst_n pulsed low mid-EMG_GREEN: light all 100 and emg_ack=0 asynchronously, then the normal sequence restarts at approach 0.
REQ-039 SHALL verify a build without TLC_EMERG_PREEMPT_EN: emg_req toggling leaves the 40-clock rotation unchanged and emg_ack stays 0.
